// File: rtl/arb_req_client.sv
// Per-channel 2-deep FIFOs feeding a single registered output stage. An external
// arbiter grants one requesting channel per cycle, and grants it combinationally.
module arb_req_client #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic [N-1:0]    req,
  input  logic [N-1:0]    grant,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic            grant_err,
  output logic [15:0]     xfer_cnt
);

  logic [DW-1:0] mem [N][2];
  logic [1:0]    cnt [N];
  logic [N-1:0]  rd_ptr, wr_ptr;
  logic [N-1:0]  full, empty, push, pop;
  logic          out_free, grant_legal, grant_bad;
  logic [IW-1:0] gnt_idx;
  logic [DW-1:0] head;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    full    = '0;
    empty   = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      full[i]  = (cnt[i] == 2'd2);
      empty[i] = (cnt[i] == 2'd0);
      if (grant[i]) gnt_idx = IW'(i);
    end
  end

  assign out_free = ~out_valid | out_ready;
  assign in_ready = ~full & {N{~rst}};
  // Requests come only from registered occupancy; a word pushed this cycle waits a cycle.
  assign req      = ~empty & {N{out_free & ~rst}};
  assign push     = in_valid & in_ready;

  // Legal grant: exactly one bit set and contained in req (req is zero when the output is stalled).
  assign grant_legal = (grant != '0) && ((grant & (grant - 1'b1)) == '0) && ((grant & ~req) == '0);
  assign grant_bad   = (grant != '0) && !grant_legal;
  assign pop         = grant_legal ? grant : '0;
  assign head        = mem[gnt_idx][rd_ptr[gnt_idx]];

  // NOTE: payload storage is not reset; occupancy counters alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= 2'd0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      grant_err <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end

      if (grant_legal) begin
        out_valid <= 1'b1;
        out_data  <= head;
        out_id    <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
      if (grant_bad) grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client: single word, backpressure, full FIFO,
// illegal grants, round-robin stream, counter wrap and mid-stream reset.
module tb_arb_req_client;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_ready;
  logic            grant_err;
  logic [15:0]     xfer_cnt;

  int checks   = 0;
  int failures = 0;

  arb_req_client #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .grant(grant), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .grant_err(grant_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, land 1 ns after the edge, and withdraw any grant.
  task automatic tick();
    @(posedge clk);
    #1;
    grant = '0;
  endtask

  initial begin
    bit hit;
    rst = 1'b1; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_req", req, 0);
    check("rst_out", {out_valid, out_data, out_id}, 0);
    check("rst_err_cnt", {grant_err, xfer_cnt}, 0);

    // Single word on channel 3
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 16'h0008; in_data[3*DW +: DW] = 8'hA5;
    #1 check("post_rst_in_ready", in_ready, 32'hFFFF);
    tick(); in_valid = '0;
    #1 check("single_req", req, 32'h0008);
    check("single_no_valid_yet", out_valid, 0);
    grant = req;
    tick();
    check("single_out", {out_valid, out_data, out_id}, {1'b1, 8'hA5, 4'd3});
    check("single_cnt_before", xfer_cnt, 0);
    tick();
    check("single_cnt_after", {out_valid, xfer_cnt}, {1'b0, 16'd1});

    // Backpressure: channel 5 output stalls while channel 6 waits
    out_ready = 1'b0;
    in_valid = 16'h0060; in_data[5*DW +: DW] = 8'h5C; in_data[6*DW +: DW] = 8'h66;
    tick(); in_valid = '0;
    #1 check("bp_req", req, 32'h0060);
    grant = 16'h0020;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_hold", {req, out_valid, out_data, out_id}, {16'h0, 1'b1, 8'h5C, 4'd5});
    end
    out_ready = 1'b1;
    #1 check("bp_release_req", req, 32'h0040);
    tick();
    check("bp_one_hs", {out_valid, xfer_cnt}, {1'b0, 16'd2});
    tick();
    check("bp_no_extra_hs", xfer_cnt, 2);
    grant = req;
    tick();
    check("bp_ch6_out", {out_valid, out_data, out_id}, {1'b1, 8'h66, 4'd6});
    tick();
    check("bp_ch6_done", {out_valid, xfer_cnt}, {1'b0, 16'd3});

    // Full channel 0: third word must be refused
    in_valid = 16'h0001; in_data[0 +: DW] = 8'h11;
    tick(); in_data[0 +: DW] = 8'h22;
    tick(); in_data[0 +: DW] = 8'h33;
    #1 check("full_not_ready", in_ready[0], 0);
    tick(); in_valid = '0;
    #1 check("full_req", req, 32'h0001);
    grant = 16'h0001;
    #1 check("full_pop_same_cycle", in_ready[0], 0);
    tick();
    check("full_ready_after_pop", in_ready[0], 1);
    check("full_first", {out_valid, out_data, out_id}, {1'b1, 8'h11, 4'd0});
    grant = req;
    tick();
    check("full_second", {out_valid, out_data, out_id}, {1'b1, 8'h22, 4'd0});
    tick();
    check("full_third_dropped", {out_valid, req}, 0);
    check("full_cnt", xfer_cnt, 5);

    // Same-cycle push and pop on channel 1 keeps occupancy at one
    in_valid = 16'h0002; in_data[1*DW +: DW] = 8'hA1;
    tick(); in_data[1*DW +: DW] = 8'hB1;
    grant = 16'h0002;
    tick(); in_valid = '0;
    check("pp_first", {out_valid, out_data, out_id}, {1'b1, 8'hA1, 4'd1});
    check("pp_occupancy", {in_ready[1], req[1]}, 2'b11);
    grant = 16'h0002;
    tick();
    check("pp_second", {out_valid, out_data, out_id}, {1'b1, 8'hB1, 4'd1});
    tick();
    check("pp_empty", {out_valid, req, xfer_cnt}, {1'b0, 16'h0, 16'd7});
    check("zero_grant_no_err", grant_err, 0);

    // Illegal grants: multi-hot, then not a subset of req
    in_valid = 16'h0001; in_data[0 +: DW] = 8'h44;
    tick(); in_valid = '0;
    grant = 16'h0003;
    tick();
    check("ill_multi", {grant_err, out_valid, req}, {1'b1, 1'b0, 16'h0001});
    grant = 16'h0002;
    tick();
    check("ill_subset", {grant_err, out_valid, req}, {1'b1, 1'b0, 16'h0001});
    grant = 16'h0001;
    tick();
    check("ill_then_legal", {out_valid, out_data, out_id, grant_err}, {1'b1, 8'h44, 4'd0, 1'b1});
    tick();

    // Round-robin stream of 32 words after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_err", {grant_err, xfer_cnt}, 0);
    in_valid = '1;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'(i * 16);
    tick();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'(i * 16 + 1);
    tick(); in_valid = '0;
    for (int w = 0; w < 2 * N; w++) begin
      grant = 16'(1 << (w % N));
      tick();
      check("stream_word", {out_valid, out_data, out_id},
            {1'b1, 8'((w % N) * 16 + w / N), 4'(w % N)});
    end
    tick();
    check("stream_done", {out_valid, xfer_cnt}, {1'b0, 16'd32});

    // xfer_cnt wrap: steady push/pop on channel 0, one handshake per cycle
    in_valid = 16'h0001; in_data[0 +: DW] = 8'h77;
    tick();
    hit = 1'b0;
    for (int c = 0; c < 70000; c++) begin
      grant = 16'h0001;
      @(posedge clk); #1;
      if (xfer_cnt == 16'hFFFF) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap_reached_ffff", hit, 1);
    @(posedge clk); #1;
    check("wrap_to_zero", xfer_cnt, 0);

    // Reset mid-stream with output stalled, channel 0 non-empty and grant_err set
    in_valid = '0; out_ready = 1'b0; grant = '0;
    tick();
    grant = 16'h0001;
    tick();
    check("pre_rst_state", {out_valid, grant_err}, 2'b11);
    rst = 1'b1; out_ready = 1'b1;
    #1 check("in_rst_comb", {in_ready, req}, 0);
    tick();
    check("mid_rst_out", {out_valid, req, xfer_cnt, grant_err}, 0);
    check("mid_rst_data", {out_data, out_id}, 0);
    rst = 1'b0;
    #1 check("mid_rst_after", {in_ready, req}, {16'hFFFF, 16'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_req_client.md
ARB_REQ_CLIENT -- requirements
Module: arb_req_client

Interface
REQ-001 The block SHALL have parameter N, default 16, the number of requesting channels (N >= 2).
REQ-002 The block SHALL have parameter DW, default 8, the payload width per channel.
REQ-003 The block SHALL have parameter IW, default $clog2(N), the width of out_id.
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  N  per-channel payload valid.
REQ-007 Port in_data  input  N*DW  per-channel payload; channel i in bits [i*DW +: DW].
REQ-008 Port in_ready  output  N  per-channel accept.
REQ-009 Port req  output  N  request vector to the external round-robin arbiter.
REQ-010 Port grant  input  N  one-hot grant from the arbiter, combinational response to req in the same cycle.
REQ-011 Port out_valid  output  1  merged output valid.
REQ-012 Port out_data  output  DW  merged output payload.
REQ-013 Port out_id  output  IW  index of the channel that sourced out_data.
REQ-014 Port out_ready  input  1  downstream accept.
REQ-015 Port grant_err  output  1  sticky protocol-violation flag.
REQ-016 Port xfer_cnt  output  16  count of completed output handshakes.

Function
REQ-017 Each channel SHALL contain a 2-entry FIFO; a push occurs on in_valid[i] & in_ready[i].
REQ-018 in_ready[i] SHALL equal ~full[i] & ~rst; there is no push-on-full even when the same channel pops in that cycle.
REQ-019 out_free SHALL equal ~out_valid | out_ready.
REQ-020 req[i] SHALL equal ~empty[i] & out_free, driven from registered FIFO state with no bypass of the current push.
REQ-021 A grant SHALL be legal only when it has exactly one bit set and (grant & ~req) == 0.
REQ-022 On a legal grant to channel k, channel k's FIFO SHALL pop, and on the next edge out_data SHALL take k's head, out_id SHALL take k, and out_valid SHALL go to 1.
REQ-023 An all-zero grant SHALL cause no pop and no error.
REQ-024 An illegal nonzero grant (multi-hot or not a subset of req) SHALL cause no pop and SHALL set grant_err, which stays set until rst.
REQ-025 If out_valid & ~out_ready, out_data and out_id SHALL hold stable, and req SHALL be all zero.
REQ-026 On out_valid & out_ready with no legal grant, out_valid SHALL clear on the next edge.
REQ-027 On out_valid & out_ready with a legal grant, the output register SHALL reload on the next edge, sustaining 1 word/cycle.
REQ-028 Latency SHALL be: push into an empty channel at cycle t, req at t+1, out_valid at t+2 if granted at t+1.
REQ-029 Each channel SHALL deliver its data in order; ordering across channels is set solely by the grant sequence.
REQ-030 xfer_cnt SHALL increment by 1 per output handshake and wrap from 0xFFFF to 0.
REQ-031 A push and a pop on the same non-full channel in the same cycle SHALL leave its occupancy unchanged.

Reset
REQ-032 While rst=1 on an edge: all FIFOs SHALL become empty, out_valid=0, out_data=0, out_id=0, grant_err=0, xfer_cnt=0.
REQ-033 While rst=1: in_ready=0 and req=0; the first cycle after rst deasserts, in_ready SHALL be all ones.
REQ-034 rst asserted mid-transfer SHALL discard all buffered and output data with no handshake counted.

Verification
REQ-035 Single word: push 0xA5 on channel 3 at t, drive grant=req at t+1 -> out_valid=1, out_data=0xA5, out_id=3 at t+2; xfer_cnt=1 after the handshake.
REQ-036 Backpressure: out_ready=0 while out_valid=1 -> req=0 and output held for 10 cycles; release -> exactly one handshake.
REQ-037 Full channel: two pushes to channel 0 with no grants -> in_ready[0]=0; third word not accepted; after one pop, in_ready[0]=1 the next cycle.
REQ-038 Illegal grant: req=0x0001 with grant=0x0003, then grant=0x0002 -> grant_err=1, FIFO occupancy unchanged, no out_valid.
REQ-039 Stream: all 16 channels loaded with two words each, out_ready=1, grant rotating round-robin -> 32 consecutive out_valid cycles, per-channel order preserved, xfer_cnt=32.
REQ-040 Reset mid-stream: assert rst with out_valid=1 and FIFOs non-empty -> next cycle out_valid=0, req=0, xfer_cnt=0, grant_err=0.
